// File: rtl/simon_button_conditioner.sv
// Button front end for the Simon game: synchronises and debounces four raw
// buttons, then classifies stable presses into single accepts, multi-presses
// and inactivity timeouts while the game waits for player input.
module simon_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn_raw,
  output logic [1:0] colour_val,
  output logic       colour_valid,
  output logic       multi_press,
  output logic       timeout,
  output logic       btn_held
);

  localparam int unsigned NB  = 4;
  localparam int unsigned DBW = 17;
  localparam int unsigned TW  = 24;

  localparam logic [DBW-1:0] DB_LIMIT  = DBW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic           TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RELEASED = 2'd1,
    PRESSED  = 2'd2,
    LOCKOUT  = 2'd3
  } state_e;

  // Synchroniser and debouncer state
  logic [NB-1:0]  sync1_q, sync1_d;
  logic [NB-1:0]  sync2_q, sync2_d;
  logic [1:0]     sync_vld_q, sync_vld_d;
  logic [NB-1:0]  cand_q, cand_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [NB-1:0]  stable_q, stable_d;
  logic           stable_vld_q, stable_vld_d;

  // Press classifier state
  state_e         state_q, state_d;
  logic [1:0]     colour_val_q, colour_val_d;
  logic           colour_valid_q, colour_valid_d;
  logic           multi_press_q, multi_press_d;
  logic           timeout_q, timeout_d;
  logic           btn_held_q, btn_held_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [DBW-1:0] run_len;
  logic           stable_zero_c;
  logic           stable_one_hot_c;
  logic [1:0]     stable_code_c;
  logic [NB-1:0]  accepted_vec_c;

  // Two-flop synchroniser; sync_vld marks when sync2 carries post-reset samples
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
  end

  // Debouncer: run_len counts consecutive identical synchronised samples,
  // including the one being taken this cycle; a full run updates stable.
  // stable_vld goes high on the first qualification after reset so the
  // classifier never acts on the reset value of stable.
  always_comb begin
    cand_d       = sync2_q;
    stable_d     = stable_q;
    stable_vld_d = stable_vld_q;
    run_len      = '0;
    if (sync_vld_q[1]) begin
      if (sync2_q == cand_q) begin
        run_len = (db_cnt_q < DB_LIMIT) ? db_cnt_q + DBW'(1) : DB_LIMIT;
      end else begin
        run_len = DBW'(1);
      end
      if (run_len >= DB_LIMIT) begin
        stable_d     = sync2_q;
        stable_vld_d = 1'b1;
      end
    end
    db_cnt_d = run_len;
  end

  // Decode helpers for the debounced vector
  assign stable_zero_c    = (stable_q == '0);
  assign stable_one_hot_c = !stable_zero_c && ((stable_q & (stable_q - NB'(1))) == '0);
  assign accepted_vec_c   = NB'(4'b0001 << colour_val_q);

  // One-hot to binary colour code
  always_comb begin
    stable_code_c = 2'd0;
    case (stable_q)
      4'b0010: stable_code_c = 2'd1;
      4'b0100: stable_code_c = 2'd2;
      4'b1000: stable_code_c = 2'd3;
      default: stable_code_c = 2'd0;
    endcase
  end

  // Classifier next state and event pulses
  always_comb begin
    state_d        = state_q;
    colour_val_d   = colour_val_q;
    colour_valid_d = 1'b0;
    multi_press_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (stable_vld_q) state_d = stable_zero_c ? RELEASED : LOCKOUT;
        end
        RELEASED: begin
          if (stable_one_hot_c) begin
            colour_valid_d = 1'b1;
            colour_val_d   = stable_code_c;
            state_d        = PRESSED;
          end else if (!stable_zero_c) begin
            multi_press_d = 1'b1;
            state_d       = LOCKOUT;
          end
        end
        PRESSED: begin
          if (stable_zero_c)                     state_d = RELEASED;
          else if (stable_q != accepted_vec_c)   state_d = LOCKOUT;
        end
        LOCKOUT: begin
          if (stable_zero_c) state_d = RELEASED;
        end
        default: state_d = IDLE;
      endcase
    end
    btn_held_d = (state_d == PRESSED);
  end

  // Inactivity timer: saturates at the limit so it fires once; an accept
  // clears it and takes priority, a multi-press defers it by one cycle
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE || colour_valid_d) begin
      tmo_cnt_d = '0;
    end else if (TMO_EN && !multi_press_d && (tmo_cnt_q < TMO_LIMIT)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      timeout_d = (tmo_cnt_q + TW'(1) == TMO_LIMIT);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      sync_vld_q     <= '0;
      cand_q         <= '0;
      db_cnt_q       <= '0;
      stable_q       <= '0;
      stable_vld_q   <= 1'b0;
      state_q        <= IDLE;
      colour_val_q   <= '0;
      colour_valid_q <= 1'b0;
      multi_press_q  <= 1'b0;
      timeout_q      <= 1'b0;
      btn_held_q     <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync_vld_q     <= sync_vld_d;
      cand_q         <= cand_d;
      db_cnt_q       <= db_cnt_d;
      stable_q       <= stable_d;
      stable_vld_q   <= stable_vld_d;
      state_q        <= state_d;
      colour_val_q   <= colour_val_d;
      colour_valid_q <= colour_valid_d;
      multi_press_q  <= multi_press_d;
      timeout_q      <= timeout_d;
      btn_held_q     <= btn_held_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign colour_val   = colour_val_q;
  assign colour_valid = colour_valid_q;
  assign multi_press  = multi_press_q;
  assign timeout      = timeout_q;
  assign btn_held     = btn_held_q;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Randomised and scenario bench for simon_button_conditioner against a
// window-based reference model of the button front end.
module tb_simon_button_conditioner;

  localparam int unsigned DB  = 4;
  localparam int unsigned TMO = 20;

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_HELD  = 2;
  localparam int M_BLOCK = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] btn_raw;
  logic [1:0] colour_val;
  logic       colour_valid;
  logic       multi_press;
  logic       timeout;
  logic       btn_held;

  simon_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .btn_raw     (btn_raw),
    .colour_val  (colour_val),
    .colour_valid(colour_valid),
    .multi_press (multi_press),
    .timeout     (timeout),
    .btn_held    (btn_held)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DUT event tallies for scenario-level checks
  int   edge_no = 0;
  int   cv_cnt = 0, mp_cnt = 0, to_cnt = 0;
  int   cv_edge = 0, to_edge = 0, held_fall_edge = 0;
  logic held_prev = 1'b0;

  // Reference model state
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic       m_primed;
  int         m_mode;
  logic [1:0] m_col;
  int         m_wait;
  logic       e_cv, e_mp, e_to, e_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_stable = 4'd0;
    m_primed = 1'b0;
    m_mode   = M_OFF;
    m_col    = 2'd0;
    m_wait   = 0;
    e_cv = 1'b0; e_mp = 1'b0; e_to = 1'b0; e_held = 1'b0;
  endtask

  // One rising edge: the debounced value is the raw value seen at edges
  // n-D-1..n-2 when all of those agree; the classifier acts on the value
  // debounced before this edge.
  task automatic model_edge(input logic e, input logic [3:0] b);
    logic [3:0] nstable;
    logic       nprimed;
    bit         same;
    int         ones;
    int         nmode;
    hist.push_back(b);
    if (hist.size() > DB + 2) hist = hist[1:$];
    nstable = m_stable;
    nprimed = m_primed;
    if (hist.size() == DB + 2) begin
      same = 1'b1;
      for (int i = 1; i < int'(DB); i++) if (hist[i] !== hist[0]) same = 1'b0;
      if (same) begin
        nstable = hist[0];
        nprimed = 1'b1;
      end
    end
    e_cv = 1'b0; e_mp = 1'b0; e_to = 1'b0;
    ones  = $countones(m_stable);
    nmode = m_mode;
    if (!e) nmode = M_OFF;
    else if (m_mode == M_OFF) begin
      if (m_primed) nmode = (ones == 0) ? M_WAIT : M_BLOCK;
    end else if (m_mode == M_WAIT) begin
      if (ones == 1) begin
        e_cv  = 1'b1;
        nmode = M_HELD;
        for (int i = 0; i < 4; i++) if (m_stable[i]) m_col = 2'(i);
      end else if (ones > 1) begin
        e_mp  = 1'b1;
        nmode = M_BLOCK;
      end
    end else if (m_mode == M_HELD) begin
      if (ones == 0) nmode = M_WAIT;
      else if (!(ones == 1 && m_stable[m_col])) nmode = M_BLOCK;
    end else begin
      if (ones == 0) nmode = M_WAIT;
    end
    if (m_mode == M_OFF || e_cv) m_wait = 0;
    else if (!e_mp && m_wait < int'(TMO)) begin
      m_wait++;
      if (m_wait == int'(TMO)) e_to = 1'b1;
    end
    m_mode   = nmode;
    e_held   = (nmode == M_HELD);
    m_stable = nstable;
    m_primed = nprimed;
  endtask

  task automatic step(input logic e, input logic [3:0] b);
    en      = e;
    btn_raw = b;
    @(posedge clk);
    model_edge(e, b);
    #1;
    edge_no++;
    check("colour_val",   32'(colour_val),   32'(m_col));
    check("colour_valid", 32'(colour_valid), 32'(e_cv));
    check("multi_press",  32'(multi_press),  32'(e_mp));
    check("timeout",      32'(timeout),      32'(e_to));
    check("btn_held",     32'(btn_held),     32'(e_held));
    if (colour_valid) begin cv_cnt++; cv_edge = edge_no; end
    if (multi_press)  mp_cnt++;
    if (timeout)      begin to_cnt++; to_edge = edge_no; end
    if (held_prev && !btn_held) held_fall_edge = edge_no;
    held_prev = btn_held;
  endtask

  task automatic run(input logic e, input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(e, b);
  endtask

  // Reset asserted between edges; outputs must clear before any clock
  task automatic async_reset(input logic [3:0] b);
    #2;
    rst = 1'b1;
    #1;
    check("rst_colour_val",   32'(colour_val),   32'd0);
    check("rst_colour_valid", 32'(colour_valid), 32'd0);
    check("rst_multi_press",  32'(multi_press),  32'd0);
    check("rst_timeout",      32'(timeout),      32'd0);
    check("rst_btn_held",     32'(btn_held),     32'd0);
    btn_raw = b;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    held_prev = 1'b0;
  endtask

  initial begin
    int t0, c0, c1;
    int len;
    int r;
    logic       re;
    logic [3:0] rb;
    rst = 1'b0; en = 1'b0; btn_raw = 4'd0;
    model_reset();

    // Single press latency, code and release
    async_reset(4'd0);
    run(1'b1, 4'd0, 8);
    t0 = edge_no; c0 = cv_cnt;
    run(1'b1, 4'b0100, 10);
    check("press_count",   32'(cv_cnt - c0),  32'd1);
    check("press_latency", 32'(cv_edge - t0), 32'd7);
    check("press_code",    32'(colour_val),   32'd2);
    check("press_held",    32'(btn_held),     32'd1);
    t0 = edge_no;
    run(1'b1, 4'd0, 10);
    check("release_latency", 32'(held_fall_edge - t0), 32'd7);

    // Bounce shorter than the debounce window is ignored
    async_reset(4'd0);
    run(1'b1, 4'd0, 8);
    c0 = cv_cnt;
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 4'b0001, 2);
      run(1'b1, 4'b0000, 2);
    end
    run(1'b1, 4'd0, 10);
    check("bounce_count", 32'(cv_cnt - c0), 32'd0);
    check("bounce_code",  32'(colour_val),  32'd0);

    // Multi-press, then narrowing to one button, then a clean press
    async_reset(4'd0);
    run(1'b1, 4'd0, 8);
    c0 = cv_cnt; c1 = mp_cnt;
    run(1'b1, 4'b0011, 8);
    run(1'b1, 4'b0001, 8);
    check("multi_count",    32'(mp_cnt - c1), 32'd1);
    check("multi_no_press", 32'(cv_cnt - c0), 32'd0);
    run(1'b1, 4'b0000, 8);
    run(1'b1, 4'b0001, 8);
    check("multi_then_press", 32'(cv_cnt - c0), 32'd1);
    check("multi_code",       32'(colour_val),  32'd0);
    check("multi_once",       32'(mp_cnt - c1), 32'd1);

    // Button already held when enabled
    async_reset(4'd0);
    run(1'b0, 4'b1000, 10);
    c0 = cv_cnt;
    run(1'b1, 4'b1000, 8);
    check("held_at_en", 32'(cv_cnt - c0), 32'd0);
    run(1'b1, 4'b0000, 8);
    run(1'b1, 4'b1000, 8);
    check("repress_count", 32'(cv_cnt - c0), 32'd1);
    check("repress_code",  32'(colour_val),  32'd3);

    // Inactivity timeout, and restart after re-enable
    async_reset(4'd0);
    run(1'b0, 4'd0, 8);
    t0 = edge_no; c0 = to_cnt;
    run(1'b1, 4'd0, 25);
    check("timeout_count", 32'(to_cnt - c0),  32'd1);
    check("timeout_edge",  32'(to_edge - t0), 32'd21);
    run(1'b0, 4'd0, 2);
    t0 = edge_no; c0 = to_cnt;
    run(1'b1, 4'd0, 25);
    check("timeout2_count", 32'(to_cnt - c0),  32'd1);
    check("timeout2_edge",  32'(to_edge - t0), 32'd21);

    // Reset in the middle of a held press and a pending debounce
    async_reset(4'd0);
    run(1'b1, 4'd0, 8);
    run(1'b1, 4'b0100, 10);
    run(1'b1, 4'b0010, 3);
    async_reset(4'b0010);
    c0 = cv_cnt;
    run(1'b1, 4'b0010, 10);
    check("post_rst_held", 32'(cv_cnt - c0), 32'd0);
    run(1'b1, 4'd0, 8);
    run(1'b1, 4'b0010, 10);
    check("post_rst_press", 32'(cv_cnt - c0), 32'd1);
    check("post_rst_code",  32'(colour_val),  32'd1);

    // Random button activity with occasional disables and resets
    for (int k = 0; k < 150; k++) begin
      re = ($urandom_range(0, 9) != 0);
      r  = int'($urandom_range(0, 19));
      if (r < 9)       rb = 4'd0;
      else if (r < 16) rb = 4'(4'b0001 << $urandom_range(0, 3));
      else             rb = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 12));
      run(re, rb, len);
      if ($urandom_range(0, 29) == 0) async_reset(4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_button_conditioner.md
SIMON_BUTTON_CONDITIONER -- requirements
Module: simon_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable synchronized cycles required before a button-state change is accepted (legal range 1..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, cycles without an accepted press before timeout fires; 0 disables timeout (legal range 0..2^24-1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 en  input  1  high while the game is waiting for player input.
REQ-006 btn_raw  input  4  raw asynchronous buttons, bit i = colour i, active-high.
REQ-007 colour_val  output  2  binary code of last accepted button (bit0->00, bit1->01, bit2->10, bit3->11).
REQ-008 colour_valid  output  1  one-cycle pulse: new single-button press accepted; colour_val valid in the same cycle.
REQ-009 multi_press  output  1  one-cycle pulse: two or more buttons became stable-pressed from released state.
REQ-010 timeout  output  1  one-cycle pulse: TIMEOUT_CYCLES elapsed without accepted press.
REQ-011 btn_held  output  1  high while FSM is in PRESSED.

Function
REQ-012 btn_raw SHALL pass through a two-flop synchronizer per bit before any other logic.
REQ-013 Debouncer: candidate register tracks synchronized vector; any mismatch reloads candidate and clears the counter; after DEBOUNCE_CYCLES consecutive matching cycles the debounced vector "stable" takes the candidate value.
REQ-014 Latency: raw change held steady -> stable update = exactly DEBOUNCE_CYCLES+2 rising edges; stable update -> colour_valid/multi_press pulse = 1 edge.
REQ-015 Debouncer SHALL run regardless of en.
REQ-016 FSM states: IDLE, RELEASED, PRESSED, LOCKOUT.
REQ-017 Any state with en=0 -> IDLE next cycle; in IDLE no pulses, timeout counter cleared.
REQ-018 IDLE with en=1: stable==0000 -> RELEASED, else -> LOCKOUT (button held at enable is ignored).
REQ-019 RELEASED: stable one-hot -> colour_valid pulse, colour_val updated, -> PRESSED; stable with >=2 bits -> multi_press pulse, -> LOCKOUT; stable==0000 -> stay.
REQ-020 PRESSED: stable==0000 -> RELEASED; stable changes to any other non-zero value -> LOCKOUT, no pulse.
REQ-021 LOCKOUT: stable==0000 -> RELEASED; otherwise stay, no pulses.
REQ-022 At most one press accepted per release; a new colour_valid requires a return through RELEASED.
REQ-023 colour_val SHALL hold its value between accepts and through IDLE.
REQ-024 Timeout counter (24 bit): increments each cycle in RELEASED, PRESSED or LOCKOUT; cleared on colour_valid and in IDLE; on reaching TIMEOUT_CYCLES pulse timeout once, then hold until cleared (no repeat, no wrap).
REQ-025 If the accept event and timeout terminal count coincide, colour_valid wins; timeout not asserted, counter cleared.
REQ-026 colour_valid, multi_press and timeout SHALL be mutually exclusive in any cycle.

Reset
REQ-027 rst asserted: synchronizer, candidate, stable, counters cleared; FSM = IDLE; colour_val=00; colour_valid=multi_press=timeout=btn_held=0, effective immediately without a clock.
REQ-028 rst mid-press or mid-debounce SHALL discard all pending state; after release of rst a still-held button is seen through IDLE->LOCKOUT rules.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-029 en=1, btn_raw=0100 held 10 cycles -> single colour_valid pulse 7 edges after change, colour_val=10, btn_held=1; release -> btn_held=0 after 7 edges.
REQ-030 btn_raw toggles 0001/0000 every 2 cycles for 20 cycles then 0000 -> no colour_valid, colour_val stays 00.
REQ-031 btn_raw=0011 stable from released -> one multi_press pulse, no colour_valid; then 0001 while still held -> no pulse; 0000 then 0001 -> colour_valid, colour_val=00.
REQ-032 en rises while btn_raw=1000 held -> no pulse; release then press 1000 -> colour_valid, colour_val=11.
REQ-033 en=1, no buttons 25 cycles -> exactly one timeout pulse 20 cycles after RELEASED entry; drop en, re-raise -> counter restarted from 0.
REQ-034 Assert rst asynchronously mid-debounce with btn_raw=0010 -> all outputs 0 before next clk edge; after rst release with button still held -> no colour_valid until released and re-pressed.
